perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised event-counter bank, the next generation of the L1 cache performance counters. It provides NUM_CH independent counters of CNT_W bits, each driven by one single-cycle event pulse, with a selectable saturate or wrap mode and sticky overflow flags. An atomic snapshot-and-clear shadow bank lets software read a coherent set of values. A registered one-cycle read port replaces per-counter output buses. It sits beside the cache controller and predictor and takes their hit/miss/eviction/stale pulses as `event_pulse` bits.

## Interface
Parameters:
- NUM_CH, 8, number of counter channels (≥1)
- CNT_W, 32, counter width in bits (≥2)
- IDX_W, 3, read index width; must satisfy 2^IDX_W ≥ NUM_CH
- SAT_EN, 1, 1 = saturate at all-ones, 0 = wrap to zero

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- event_pulse  in  NUM_CH  bit i = one event on channel i this cycle
- count_en  in  1  global count enable; events are ignored while low
- clear  in  1  zero all live counters and all ovf flags
- snap_req  in  1  copy all live counters into the shadow bank
- rd_req  in  1  read request, one per cycle allowed
- rd_idx  in  IDX_W  channel to read
- rd_shadow  in  1  1 = read the shadow bank, 0 = read the live bank
- rd_valid  out  1  read data valid, pulses for one cycle
- rd_data  out  CNT_W  read data
- ovf  out  NUM_CH  sticky per-channel overflow flags

## Operation
- Live counter i increments by 1 when `count_en` and `event_pulse[i]` are both high. Each channel counts independently; all channels may increment in the same cycle.
- Overflow on an event at all-ones:
  - SAT_EN=1: the counter holds at all-ones.
  - SAT_EN=0: the counter goes to 0.
  - In both modes, `ovf[i]` sets and stays set.
  - A counter that is already saturated and receives further events stays at all-ones and `ovf[i]` stays 1.
- `clear`:
  - Next cycle, all live counters and all ovf bits are 0.
  - `clear` has priority over events in the same cycle; those events are lost.
  - `clear` does not touch the shadow bank.
- `snap_req`: the shadow bank captures the live values present before this edge, i.e. excluding the current cycle's events.
- `snap_req` and `clear` together form an atomic snapshot-and-clear: the shadow gets the pre-clear values and the live bank becomes 0. No event is counted in either bank for that cycle.
- Read:
  - On `rd_req`, the selected value (live or shadow at `rd_idx`, as it was before this edge) is registered into `rd_data`.
  - `rd_idx` ≥ NUM_CH returns 0 and still asserts `rd_valid`.
- A read coinciding with `snap_req` or `clear` returns the pre-update value.
- `rd_data` holds its last value while `rd_valid` is low.

## Timing
- Reset (rst_n low at an edge): all live counters, shadow counters, `ovf`, `rd_valid` and `rd_data` become 0. This applies mid-operation; any in-flight read is dropped (`rd_valid` is 0 the next cycle).
- Event latency: a pulse at edge N is visible in the live counter after edge N and is readable by an `rd_req` sampled at edge N+1.
- Read latency: `rd_req` sampled at edge N → `rd_valid`=1 and `rd_data` valid after edge N. Back-to-back requests give back-to-back valid cycles. There is no backpressure.
- `ovf[i]` rises in the same cycle the overflowing value is written.
- Width rules:
  - Increments are performed at CNT_W+1 bits; the carry-out is the overflow condition.
  - The shadow bank and `rd_data` are exactly CNT_W bits.

## Test plan
- Reset, then 5 pulses on ch0 and 3 simultaneous pulses on ch0 and ch7 → reading live idx 0 gives 8 and idx 7 gives 3. `rd_valid` is exactly 1 cycle after each `rd_req`, and `ovf`=0.
- CNT_W=4, SAT_EN=1: 17 pulses on ch2 → reads 15 and `ovf[2]`=1. With SAT_EN=0, the same stimulus reads 1 and `ovf[2]`=1. `clear` then reads 0 and `ovf`=0.
- Ch1 at 10 with `clear`, `snap_req` and `event_pulse[1]` in the same cycle → shadow idx 1 reads 10 and live idx 1 reads 0. One further pulse gives live 1 and shadow 10.
- `count_en`=0 with 4 pulses on ch3 → reads 0. With `count_en`=1 and 4 more pulses → reads 4.
- NUM_CH=6, IDX_W=3: read idx 6 and 7 → `rd_data`=0 and `rd_valid`=1. Back-to-back reads of idx 0..5 return the correct values on consecutive cycles.
- Counters nonzero and `rd_req` asserted, with `rst_n` low in the same cycle → next cycle `rd_valid`=0, and all reads after reset return 0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// -----------------------------------------------------------------------------
// This module is a bank of NUM_CH independent event counters, each CNT_W bits
// wide. It is intended for cache and predictor performance monitoring.
//
// Each channel counts single-cycle event pulses. A counter either saturates at
// all-ones or wraps to zero, depending on SAT_EN. Each channel also has a
// sticky overflow flag.
//
// A shadow bank captures every live counter on snap_req. Asserting snap_req
// together with clear gives an atomic snapshot-and-clear.
//
// Values are read through a registered read port with one cycle of latency.
//
// Parameters:
//   NUM_CH  number of channels (>= 1)
//   CNT_W   counter width in bits (>= 2)
//   IDX_W   read index width, 2**IDX_W >= NUM_CH
//   SAT_EN  1 = saturate at all-ones, 0 = wrap to zero
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   event_pulse  per-channel event pulse
//   count_en     global count enable
//   clear        zero live counters and overflow flags
//   snap_req     copy live counters into the shadow bank
//   rd_req       read request (one per cycle)
//   rd_idx       channel to read
//   rd_shadow    1 = read shadow bank, 0 = read live bank
//   rd_valid     read data valid (one-cycle pulse per request)
//   rd_data      read data, held while rd_valid is low
//   ovf          sticky per-channel overflow flags
// -----------------------------------------------------------------------------
module perf_counter_bank #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 3,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] event_pulse,
  input  logic              count_en,
  input  logic              clear,
  input  logic              snap_req,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_shadow,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);

  localparam int NUM_SLOTS = 2 ** IDX_W;

  // Per-channel views of the live and shadow banks.
  logic [CNT_W-1:0] w_live   [NUM_CH];
  logic [CNT_W-1:0] w_shadow [NUM_CH];

  // The read mux sees banks padded out to every encodable index.
  // Indices with no channel behind them read as zero.
  logic [CNT_W-1:0] w_live_pad   [NUM_SLOTS];
  logic [CNT_W-1:0] w_shadow_pad [NUM_SLOTS];

  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] w_rd_sel;

  // ---------------------------------------------------------------------------
  // Per-channel counter, overflow flag and shadow register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_shadow;
      logic             r_ovf;
      logic [CNT_W:0]   w_inc;
      logic             w_carry;
      logic             w_hit;

      // The increment is one bit wider than the counter.
      // Its carry-out is exactly the overflow condition.
      assign w_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
      assign w_carry = w_inc[CNT_W];
      assign w_hit   = count_en & event_pulse[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else if (clear) begin
          // Clear wins over events in the same cycle; those events are lost.
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else if (w_hit) begin
          if (w_carry) begin
            // The low bits of w_inc are already zero on wrap.
            r_cnt <= (SAT_EN != 0) ? {CNT_W{1'b1}} : w_inc[CNT_W-1:0];
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= w_inc[CNT_W-1:0];
          end
        end
      end

      // The shadow register takes the value present before this edge.
      // Combined with clear, this makes snapshot-and-clear atomic.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_shadow <= '0;
        end else if (snap_req) begin
          r_shadow <= r_cnt;
        end
      end

      assign w_live[gi]   = r_cnt;
      assign w_shadow[gi] = r_shadow;
      assign ovf[gi]      = r_ovf;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Padding of the banks to the full index space
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_real
        assign w_live_pad[gi]   = w_live[gi];
        assign w_shadow_pad[gi] = w_shadow[gi];
      end else begin : g_empty
        assign w_live_pad[gi]   = '0;
        assign w_shadow_pad[gi] = '0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_sel = '0;
    if (rd_shadow) begin
      w_rd_sel = w_shadow_pad[rd_idx];
    end else begin
      w_rd_sel = w_live_pad[rd_idx];
    end
  end

  // The read samples pre-edge bank contents.
  // A read in the same cycle as snap_req or clear therefore sees the old value.
  // A reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_sel;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank.
//
// Three configurations run side by side from shared stimulus:
//   k=0 : defaults (8 channels, 32-bit, saturating)
//   k=1 : 6 channels, 4-bit, saturating
//   k=2 : 6 channels, 4-bit, wrapping
//
// A behavioural model tracks every counter as an integer and predicts each
// read, valid pulse and overflow flag.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ev;
  logic       count_en;
  logic       clear;
  logic       snap_req;
  logic       rd_req;
  logic [2:0] rd_idx;
  logic       rd_shadow;

  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b, rd_data_c;
  logic [7:0]  ovf_a;
  logic [5:0]  ovf_b, ovf_c;

  logic        rv  [3];
  logic [31:0] rdd [3];
  logic [7:0]  ovo [3];

  assign rv[0]  = rd_valid_a;
  assign rv[1]  = rd_valid_b;
  assign rv[2]  = rd_valid_c;
  assign rdd[0] = rd_data_a;
  assign rdd[1] = {28'd0, rd_data_b};
  assign rdd[2] = {28'd0, rd_data_c};
  assign ovo[0] = ovf_a;
  assign ovo[1] = {2'b00, ovf_b};
  assign ovo[2] = {2'b00, ovf_c};

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(8), .CNT_W(32), .IDX_W(3), .SAT_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .event_pulse(ev), .count_en(count_en),
    .clear(clear), .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_shadow(rd_shadow), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .ovf(ovf_a));

  perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .IDX_W(3), .SAT_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .event_pulse(ev[5:0]), .count_en(count_en),
    .clear(clear), .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_shadow(rd_shadow), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .ovf(ovf_b));

  perf_counter_bank #(.NUM_CH(6), .CNT_W(4), .IDX_W(3), .SAT_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .event_pulse(ev[5:0]), .count_en(count_en),
    .clear(clear), .snap_req(snap_req), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_shadow(rd_shadow), .rd_valid(rd_valid_c), .rd_data(rd_data_c), .ovf(ovf_c));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int unsigned checks   = 0;
  int unsigned failures = 0;

  longint      m_live [3][8];
  longint      m_sh   [3][8];
  bit          m_ovf  [3][8];
  logic [31:0] exp_rd [3];
  logic        exp_v;

  localparam longint MAXV [3] = '{64'd4294967295, 64'd15, 64'd15};
  localparam int     NCH  [3] = '{8, 6, 6};
  localparam bit     SAT  [3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [7:0] exp_ovf(input int k);
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < NCH[k]; c++) v[c] = m_ovf[k][c];
    return v;
  endfunction

  // Drive one cycle of stimulus, advance the model across the edge, and wait
  // until the outputs have settled.
  task automatic step(input logic [7:0] e, input bit cen, input bit clr, input bit snap,
                      input bit rq, input int idx, input bit shd);
    ev = e; count_en = cen; clear = clr; snap_req = snap;
    rd_req = rq; rd_idx = 3'(idx); rd_shadow = shd;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        for (int c = 0; c < 8; c++) begin
          m_live[k][c] = 0; m_sh[k][c] = 0; m_ovf[k][c] = 0;
        end
        exp_rd[k] = '0;
      end else begin
        if (rq) begin
          if (idx >= NCH[k]) exp_rd[k] = '0;
          else exp_rd[k] = 32'(shd ? m_sh[k][idx] : m_live[k][idx]);
        end
        if (snap) for (int c = 0; c < NCH[k]; c++) m_sh[k][c] = m_live[k][c];
        if (clr) begin
          for (int c = 0; c < 8; c++) begin
            m_live[k][c] = 0; m_ovf[k][c] = 0;
          end
        end else if (cen) begin
          for (int c = 0; c < NCH[k]; c++) begin
            if (e[c]) begin
              if (m_live[k][c] == MAXV[k]) begin
                m_ovf[k][c]  = 1;
                m_live[k][c] = SAT[k] ? MAXV[k] : 0;
              end else begin
                m_live[k][c] = m_live[k][c] + 1;
              end
            end
          end
        end
      end
    end
    exp_v = rst_n & rq;
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input logic [7:0] e, input int n);
    for (int i = 0; i < n; i++) step(e, 1, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    step(8'h00, 0, 0, 0, 1, 0, 0);
    step(8'h00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rv[k] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got %0b want 0", k, rv[k]); end
      checks++;
      if (rdd[k] !== 32'd0) begin failures++; $display("FAIL reset_data dut%0d got %0h want 0", k, rdd[k]); end
      checks++;
      if (ovo[k] !== 8'd0) begin failures++; $display("FAIL reset_ovf dut%0d got %0h want 0", k, ovo[k]); end
    end
  endtask

  task automatic test_basic;
    logic [31:0] want7 [3];
    want7 = '{32'd3, 32'd0, 32'd0};
    pulses(8'h01, 5);
    pulses(8'h81, 3);
    step(8'h00, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rv[k] !== 1'b1) begin failures++; $display("FAIL basic_valid0 dut%0d got %0b want 1", k, rv[k]); end
      checks++;
      if (rdd[k] !== 32'd8) begin failures++; $display("FAIL basic_idx0 dut%0d got %0d want 8", k, rdd[k]); end
    end
    step(8'h00, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rv[k] !== 1'b0) begin failures++; $display("FAIL basic_pulse_width dut%0d got %0b want 0", k, rv[k]); end
      checks++;
      if (rdd[k] !== 32'd8) begin failures++; $display("FAIL basic_hold dut%0d got %0d want 8", k, rdd[k]); end
    end
    step(8'h00, 1, 0, 0, 1, 7, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== want7[k] || rv[k] !== 1'b1) begin
        failures++; $display("FAIL basic_idx7 dut%0d got %0d/v%0b want %0d/v1", k, rdd[k], rv[k], want7[k]);
      end
      checks++;
      if (ovo[k] !== 8'd0) begin failures++; $display("FAIL basic_ovf dut%0d got %0h want 0", k, ovo[k]); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] want [3];
    want = '{32'd17, 32'd15, 32'd1};
    step(8'h00, 1, 1, 0, 0, 0, 0);
    pulses(8'h04, 17);
    step(8'h00, 1, 0, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== want[k]) begin failures++; $display("FAIL ovf_value dut%0d got %0d want %0d", k, rdd[k], want[k]); end
      checks++;
      if (ovo[k][2] !== (k != 0)) begin failures++; $display("FAIL ovf_flag dut%0d got %0b want %0b", k, ovo[k][2], k != 0); end
    end
    // Further events on a saturated counter keep it pinned and flagged.
    pulses(8'h04, 3);
    step(8'h00, 1, 0, 0, 1, 2, 0);
    checks++;
    if (rd_data_b !== 4'd15 || ovf_b[2] !== 1'b1) begin
      failures++; $display("FAIL ovf_sat_hold got %0d/%0b want 15/1", rd_data_b, ovf_b[2]);
    end
    step(8'h00, 1, 1, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'd0 || ovo[k] !== 8'd0) begin
        failures++; $display("FAIL ovf_clear dut%0d got %0d/%0h want 0/0", k, rdd[k], ovo[k]);
      end
    end
  endtask

  task automatic test_snap_clear;
    step(8'h00, 1, 1, 0, 0, 0, 0);
    pulses(8'h02, 10);
    step(8'h02, 1, 1, 1, 0, 0, 0);
    step(8'h00, 1, 0, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'd10) begin failures++; $display("FAIL snap_shadow dut%0d got %0d want 10", k, rdd[k]); end
    end
    step(8'h00, 1, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'd0) begin failures++; $display("FAIL snap_live dut%0d got %0d want 0", k, rdd[k]); end
    end
    pulses(8'h02, 1);
    step(8'h00, 1, 0, 0, 1, 1, 0);
    checks++;
    if (rd_data_a !== 32'd1) begin failures++; $display("FAIL snap_live_after got %0d want 1", rd_data_a); end
    step(8'h00, 1, 0, 0, 1, 1, 1);
    checks++;
    if (rd_data_a !== 32'd10) begin failures++; $display("FAIL snap_shadow_after got %0d want 10", rd_data_a); end
  endtask

  task automatic test_count_en;
    step(8'h00, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(8'h08, 0, 0, 0, 0, 0, 0);
    step(8'h00, 1, 0, 0, 1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'd0) begin failures++; $display("FAIL cen_off dut%0d got %0d want 0", k, rdd[k]); end
    end
    pulses(8'h08, 4);
    step(8'h00, 1, 0, 0, 1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'd4) begin failures++; $display("FAIL cen_on dut%0d got %0d want 4", k, rdd[k]); end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) step(8'($urandom), 1, 0, 0, 0, 0, 0);
    for (int idx = 0; idx < 8; idx++) begin
      step(8'h00, 1, 0, 0, 1, idx, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rv[k] !== 1'b1 || rdd[k] !== exp_rd[k]) begin
          failures++;
          $display("FAIL b2b idx%0d dut%0d got %0d/v%0b want %0d/v1", idx, k, rdd[k], rv[k], exp_rd[k]);
        end
      end
      if (idx >= 6) begin
        checks++;
        if (rd_data_b !== 4'd0 || rd_data_c !== 4'd0) begin
          failures++; $display("FAIL b2b_oob idx%0d got %0d/%0d want 0/0", idx, rd_data_b, rd_data_c);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom), ($urandom % 8) != 0, ($urandom % 50) == 0, ($urandom % 10) == 0,
           ($urandom % 3) != 0, int'($urandom % 8), ($urandom % 2) == 1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rv[k] !== exp_v) begin failures++; $display("FAIL rnd_valid cyc%0d dut%0d got %0b want %0b", i, k, rv[k], exp_v); end
        checks++;
        if (rdd[k] !== exp_rd[k]) begin failures++; $display("FAIL rnd_data cyc%0d dut%0d got %0h want %0h", i, k, rdd[k], exp_rd[k]); end
        checks++;
        if (ovo[k] !== exp_ovf(k)) begin failures++; $display("FAIL rnd_ovf cyc%0d dut%0d got %0h want %0h", i, k, ovo[k], exp_ovf(k)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    pulses(8'hff, 5);
    step(8'h00, 1, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    step(8'hff, 1, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rv[k] !== 1'b0) begin failures++; $display("FAIL rstmid_valid dut%0d got %0b want 0", k, rv[k]); end
      checks++;
      if (rdd[k] !== 32'd0 || ovo[k] !== 8'd0) begin
        failures++; $display("FAIL rstmid_state dut%0d got %0h/%0h want 0/0", k, rdd[k], ovo[k]);
      end
    end
    for (int s = 0; s < 2; s++) begin
      for (int idx = 0; idx < 8; idx++) begin
        step(8'h00, 0, 0, 0, 1, idx, s == 1);
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (rdd[k] !== 32'd0 || rv[k] !== 1'b1) begin
            failures++; $display("FAIL rstmid_read s%0d idx%0d dut%0d got %0h/v%0b want 0/v1", s, idx, k, rdd[k], rv[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ev = '0; count_en = 1'b0; clear = 1'b0; snap_req = 1'b0;
    rd_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0;
    for (int k = 0; k < 3; k++) exp_rd[k] = '0;
    exp_v = 1'b0;
    test_reset;
    test_basic;
    test_overflow;
    test_snap_clear;
    test_count_en;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
